// File: rtl/un_striping_n_if.sv
// Lane-side write bus and reassembled output stream of the N-lane un-striper.
interface un_striping_n_if #(
    parameter int NUM_LANES = 4,
    parameter int WIDTH     = 32
);
    logic [NUM_LANES*WIDTH-1:0] lane_data;
    logic [NUM_LANES-1:0]       lane_valid;
    logic [NUM_LANES-1:0]       lane_ready;
    logic [WIDTH-1:0]           data_out;
    logic                       valid_out;
    logic                       ready_in;

    modport master (
        output lane_data, lane_valid, ready_in,
        input  lane_ready, data_out, valid_out
    );

    modport slave (
        input  lane_data, lane_valid, ready_in,
        output lane_ready, data_out, valid_out
    );
endinterface

// File: rtl/un_striping_n.sv
// Merges NUM_LANES striped lanes, each buffered in a show-ahead FIFO, back into
// one ordered stream; a round-robin pointer restores lane order 0..N-1.
module un_striping_n #(
    parameter int NUM_LANES = 4,
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         clk_f,
    input  logic                         reset,
    un_striping_n_if.slave               bus,
    output logic [$clog2(NUM_LANES)-1:0] lane_ptr,
    output logic                         aligned,
    output logic [NUM_LANES-1:0]         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NUM_LANES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        ptr_nxt;
    logic [AW:0]          wr_ptr [NUM_LANES];
    logic [AW:0]          rd_ptr [NUM_LANES];
    logic [WIDTH-1:0]     mem    [NUM_LANES][DEPTH];
    logic [NUM_LANES-1:0] full, empty, push, pop;
    logic [WIDTH-1:0]     head;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    always_comb begin
        full  = '0;
        empty = '0;
        push  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            full[i]  = (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]) && (wr_ptr[i][AW] != rd_ptr[i][AW]);
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            push[i]  = bus.lane_valid[i] && !full[i];
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            pop[i] = bus.valid_out && bus.ready_in && (lane_ptr == PW'(i));
        end
    end

    assign bus.lane_ready = ~full;
    assign head           = mem[lane_ptr][rd_ptr[lane_ptr][AW-1:0]];
    assign aligned        = (state == RUN);

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = lane_ptr;
        bus.valid_out = 1'b0;
        bus.data_out  = '0;
        case (state)
            IDLE: begin
                if (empty == '0) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.valid_out = !empty[lane_ptr];
                if (bus.valid_out) begin
                    bus.data_out = head;
                end
                if (bus.valid_out && bus.ready_in) begin
                    ptr_nxt = (lane_ptr == PW'(NUM_LANES - 1)) ? '0 : lane_ptr + PW'(1);
                end
                // A fully drained round ends the frame so the next burst re-aligns.
                if ((lane_ptr == '0) && (empty == '1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lane_ptr <= '0;
            overflow <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            lane_ptr <= ptr_nxt;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                if (bus.lane_valid[i] && full[i]) begin
                    overflow[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_f) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= bus.lane_data[i*WIDTH +: WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_un_striping_n.sv
// Scoreboard bench for un_striping_n: directed lane bursts, expected words queued
// at issue time and popped by a monitor whenever an output word is accepted.
module tb_un_striping_n;
    localparam int NL = 4;
    localparam int W  = 32;
    localparam int D  = 4;

    logic          clk_f = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    lane_ptr;
    logic          aligned;
    logic [NL-1:0] overflow;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [W-1:0]  exp_q[$];

    un_striping_n_if #(.NUM_LANES(NL), .WIDTH(W)) bus();

    un_striping_n #(.NUM_LANES(NL), .WIDTH(W), .DEPTH(D)) dut (
        .clk_f    (clk_f),
        .reset    (reset),
        .bus      (bus),
        .lane_ptr (lane_ptr),
        .aligned  (aligned),
        .overflow (overflow)
    );

    always #5 clk_f = ~clk_f;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_f) begin
        if (!reset && bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got 0x%0h expected none at %0t", bus.data_out, $time);
            end else begin
                chk("data_out", bus.data_out, exp_q.pop_front());
            end
        end
    end

    task automatic drive_row(input logic [NL-1:0] v, input logic [W-1:0] d0, d1, d2, d3);
        bus.lane_valid = v;
        bus.lane_data  = {d3, d2, d1, d0};
        @(posedge clk_f);
        #1;
        bus.lane_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_f);
        #1;
    endtask

    task automatic expect_words(input logic [W-1:0] w[]);
        foreach (w[i]) exp_q.push_back(w[i]);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk_f);
            #1;
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d words left expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.lane_valid = '0;
        bus.lane_data  = '0;
        bus.ready_in   = 1'b0;

        // Reset state
        #2;
        chk("rst_valid_out", bus.valid_out, 0);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_lane_ptr", lane_ptr, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_lane_ready", bus.lane_ready, 4'b1111);
        #10 reset = 1'b0;
        idle(1);

        // Aligned burst
        bus.ready_in = 1'b1;
        expect_words('{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1, 32'hB2, 32'hB3});
        drive_row(4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        chk("burst_idle_before", aligned, 0);
        drive_row(4'b1111, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        chk("burst_aligned", aligned, 1);
        idle(8);
        chk("burst_throughput", exp_q.size(), 0);
        wait_drain("burst");
        idle(3);
        chk("burst_end_aligned", aligned, 0);
        chk("burst_end_valid", bus.valid_out, 0);

        // Skew: lane 2 lags by two cycles
        expect_words('{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1, 32'hB2, 32'hB3});
        drive_row(4'b1011, 32'hA0, 32'hA1, 32'h0, 32'hA3);
        drive_row(4'b1011, 32'hB0, 32'hB1, 32'h0, 32'hB3);
        chk("skew_valid_wait", bus.valid_out, 0);
        drive_row(4'b0100, 32'h0, 32'h0, 32'hA2, 32'h0);
        chk("skew_valid_landed", bus.valid_out, 0);
        drive_row(4'b0100, 32'h0, 32'h0, 32'hB2, 32'h0);
        wait_drain("skew");
        chk("skew_overflow", overflow, 0);
        idle(3);

        // Backpressure holding A1
        bus.ready_in = 1'b0;
        expect_words('{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1, 32'hB2, 32'hB3});
        drive_row(4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        drive_row(4'b1111, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        idle(2);
        bus.ready_in = 1'b1;
        idle(1);
        bus.ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_data_hold", bus.data_out, 32'hA1);
            chk("bp_ptr_hold", lane_ptr, 1);
            chk("bp_valid_hold", bus.valid_out, 1);
            idle(1);
        end
        bus.ready_in = 1'b1;
        wait_drain("bp");
        idle(3);

        // Overflow on lane 1
        bus.ready_in = 1'b0;
        expect_words('{32'h20, 32'h10, 32'h22, 32'h23, 32'h30, 32'h11, 32'h32, 32'h33,
                       32'h40, 32'h12, 32'h42, 32'h43, 32'h50, 32'h13, 32'h52, 32'h53});
        drive_row(4'b1111, 32'h20, 32'h10, 32'h22, 32'h23);
        drive_row(4'b0010, 32'h0, 32'h11, 32'h0, 32'h0);
        drive_row(4'b0010, 32'h0, 32'h12, 32'h0, 32'h0);
        chk("ovf_ready_3rd", bus.lane_ready, 4'b1111);
        drive_row(4'b0010, 32'h0, 32'h13, 32'h0, 32'h0);
        chk("ovf_ready_4th", bus.lane_ready, 4'b1101);
        chk("ovf_clear_4th", overflow, 4'b0000);
        drive_row(4'b0010, 32'h0, 32'h14, 32'h0, 32'h0);
        chk("ovf_flag_5th", overflow, 4'b0010);
        bus.ready_in = 1'b1;
        drive_row(4'b1101, 32'h30, 32'h0, 32'h32, 32'h33);
        drive_row(4'b1101, 32'h40, 32'h0, 32'h42, 32'h43);
        drive_row(4'b1101, 32'h50, 32'h0, 32'h52, 32'h53);
        wait_drain("ovf");
        idle(3);
        chk("ovf_sticky", overflow, 4'b0010);
        chk("ovf_end_aligned", aligned, 0);

        // Mid-round underflow at lane 2
        expect_words('{32'h60, 32'h61, 32'h62, 32'h63, 32'h70, 32'h71});
        drive_row(4'b1111, 32'h60, 32'h61, 32'h62, 32'h63);
        drive_row(4'b0011, 32'h70, 32'h71, 32'h0, 32'h0);
        wait_drain("under_a");
        idle(2);
        chk("under_valid", bus.valid_out, 0);
        chk("under_ptr", lane_ptr, 2);
        chk("under_aligned", aligned, 1);
        expect_words('{32'h72, 32'h73});
        drive_row(4'b1100, 32'h0, 32'h0, 32'h72, 32'h73);
        wait_drain("under_b");
        idle(3);
        chk("under_end_aligned", aligned, 0);

        // Asynchronous reset mid-stream
        bus.ready_in = 1'b0;
        drive_row(4'b1111, 32'h80, 32'h81, 32'h82, 32'h83);
        drive_row(4'b1111, 32'h90, 32'h91, 32'h92, 32'h93);
        drive_row(4'b0001, 32'hE0, 32'h0, 32'h0, 32'h0);
        drive_row(4'b0001, 32'hE1, 32'h0, 32'h0, 32'h0);
        drive_row(4'b0001, 32'hE2, 32'h0, 32'h0, 32'h0);
        chk("mid_pre_overflow", overflow, 4'b0011);
        chk("mid_pre_valid", bus.valid_out, 1);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_valid", bus.valid_out, 0);
        chk("mid_rst_data", bus.data_out, 0);
        chk("mid_rst_ptr", lane_ptr, 0);
        chk("mid_rst_aligned", aligned, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_ready", bus.lane_ready, 4'b1111);
        #10 reset = 1'b0;
        idle(1);
        bus.ready_in = 1'b1;
        expect_words('{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hD0, 32'hD1, 32'hD2, 32'hD3});
        drive_row(4'b1111, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
        drive_row(4'b1111, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
        wait_drain("post_rst");
        idle(3);
        chk("post_rst_aligned", aligned, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/un_striping_n.md
Name: un_striping_n

Overview:
- Parametrised successor to the 2-lane un-striper.
- Merges NUM_LANES striped lanes back into one ordered WIDTH-bit stream.
- Each lane feeds a small show-ahead FIFO. A round-robin pointer reassembles words in lane order 0,1,…,N-1,0,…
- Lane start-up skew is absorbed by an alignment state. The output has valid/ready backpressure, and lane overflow is flagged per lane.

Parameters:
NUM_LANES, 4, number of striped input lanes (>=2)
WIDTH, 32, data word width in bits
DEPTH, 4, per-lane FIFO depth in words (power of 2, >=2)

Ports:
clk_f  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
lane_data  input  NUM_LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
lane_valid  input  NUM_LANES  per-lane write strobe
lane_ready  output  NUM_LANES  per-lane FIFO not full
data_out  output  WIDTH  reassembled word
valid_out  output  1  data_out holds a valid word
ready_in  input  1  downstream accepts data_out this cycle
lane_ptr  output  $clog2(NUM_LANES)  lane currently selected for output
aligned  output  1  high while in RUN state
overflow  output  NUM_LANES  sticky: a lane was written while its FIFO was full

Behaviour:
- Reset (asynchronous, any time, including mid-stream):
  - FIFOs emptied, lane_ptr=0, state=IDLE.
  - Outputs: valid_out=0, data_out=0, aligned=0, overflow=0, lane_ready=all 1.
- Lane FIFO write:
  - Push when lane_valid[i] && lane_ready[i].
  - lane_ready[i] = !full[i], evaluated on pre-pop occupancy; there is no write-through when full.
- Lane FIFO overflow:
  - lane_valid[i] while full[i]: the word is dropped and overflow[i] is set.
  - overflow[i] stays set until reset.
- Show-ahead: a word written at edge k is at the FIFO head and visible from the cycle after edge k.
- State IDLE:
  - valid_out=0, data_out=0, lane_ptr=0.
  - Goes to RUN on the edge where every lane FIFO is non-empty. This absorbs lane skew up to DEPTH-1 words.
  - Lanes may keep filling while in IDLE.
- State RUN:
  - aligned=1.
  - valid_out = !empty[lane_ptr].
  - data_out = head of FIFO[lane_ptr] when valid_out, else 0.
  - On valid_out && ready_in: pop FIFO[lane_ptr]; lane_ptr advances (NUM_LANES-1 wraps to 0).
- Stall conditions:
  - Empty current lane: valid_out=0, lane_ptr holds, state stays RUN. Order is never skipped.
  - valid_out && !ready_in: data_out and lane_ptr hold, no pop.
- Frame end: in RUN, if lane_ptr==0 and all FIFOs are empty at the start of a cycle, the next state is IDLE. Every new burst therefore re-aligns starting at lane 0.
- Simultaneous push and pop on the same FIFO: both take effect; occupancy is unchanged.
- Throughput: one word per clk_f when lanes are fed and ready_in=1.
- Arithmetic:
  - FIFO pointers are $clog2(DEPTH)+1 bits.
  - full when the low bits are equal and the MSBs differ.
  - empty when the pointers are fully equal.

Test Plan:
- Aligned burst, defaults:
  - Stimulus: in one cycle write lanes 0..3 = 0xA0,0xA1,0xA2,0xA3, then next cycle 0xB0..0xB3; ready_in=1.
  - Required: aligned rises once all lanes are non-empty; data_out sequence A0,A1,A2,A3,B0,B1,B2,B3 on consecutive cycles; then returns to IDLE with aligned=0.
- Skew:
  - Stimulus: lane 2 starts 2 cycles after the others, values as above.
  - Required: valid_out stays 0 until lane 2's first word lands; output order is identical to the aligned case; no overflow.
- Backpressure:
  - Stimulus: ready_in=0 for 3 cycles while valid_out=1 showing 0xA1.
  - Required: data_out holds 0xA1 and lane_ptr holds 1; the sequence resumes A2,A3 when ready_in=1.
- Overflow:
  - Stimulus: DEPTH=4, ready_in=0; write lane 1 five times (0x10..0x14), other lanes one word each.
  - Required: lane_ready[1]=0 after the 4th write; overflow=4'b0010 after the 5th write.
  - Required on drain: lane 1 yields 0x10..0x13 only; 0x14 never appears.
- Mid-round underflow:
  - Stimulus: lanes 0,1 supply 2 words, lanes 2,3 supply 1 word.
  - Required: after the first round, lanes 0,1 output; valid_out=0 with lane_ptr=2 and aligned=1 until lane 2 is refilled; then ordered output continues.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously (between edges) while in RUN with FIFOs partly full and overflow set.
  - Required: immediately valid_out=0, data_out=0, lane_ptr=0, aligned=0, overflow=0, lane_ready=4'b1111.
  - Required after release: a fresh burst outputs correctly from lane 0.
